// File: rtl/wb_pkg.sv
// Shared writeback types: register-file geometry and the queued late-result entry.
// Combinational definitions only; no latency or backpressure of its own.
// Used by wb_fifo and wb_port_arbiter.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Late-result queue of wb_entry_t with power-of-two DEPTH and wrapping pointers.
// Push lands at the clock edge and head is visible the next cycle.
// A push while full and a pop while empty are both ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output wb_entry_t     head
);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges pipeline writebacks (priority) with queued late results onto the regfile write port; optional WB_BYPASS_EN.
// Pipeline write appears 1 cycle later; a late result at least 2 cycles after its handshake.
// late_ready drops when the queue is full; stall_req asks the hazard unit for bubbles so the queue drains.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STALL_MARGIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              late_valid,
  input  logic [REG_AW-1:0] late_rd,
  input  logic [XLEN-1:0]   late_data,
  output logic              late_ready,
  output logic              stall_req,
  output logic              RegWrite,
  output logic [REG_AW-1:0] w_add,
  output logic [XLEN-1:0]   RegWriteData
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] byp_rs1,
  input  logic [REG_AW-1:0] byp_rs2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [XLEN-1:0]   byp1_data,
  output logic [XLEN-1:0]   byp2_data
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  wb_entry_t     fifo_head;
  wb_entry_t     late_entry;
  logic          late_push;
  logic          pipe_sel;
  logic          late_pop;
  logic [31:0]   free_slots;

  assign late_entry = '{rd: late_rd, data: late_data};

  // x0 results complete their handshake but never occupy a slot.
  assign late_ready = ~fifo_full;
  assign late_push  = late_valid & late_ready & (late_rd != '0);
  assign pipe_sel   = wb_valid & (wb_rd != '0);
  assign late_pop   = ~pipe_sel & ~fifo_empty;

  assign free_slots = 32'(DEPTH) - 32'(fifo_count);
  assign stall_req  = (free_slots <= 32'(STALL_MARGIN));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (late_push),
    .push_dat (late_entry),
    .pop      (late_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  // Address and data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWrite     <= 1'b0;
      w_add        <= '0;
      RegWriteData <= '0;
    end else if (pipe_sel) begin
      RegWrite     <= 1'b1;
      w_add        <= wb_rd;
      RegWriteData <= wb_data;
    end else if (late_pop) begin
      RegWrite     <= 1'b1;
      w_add        <= fifo_head.rd;
      RegWriteData <= fifo_head.data;
    end else begin
      RegWrite     <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Regfile writes at the edge, so a same-cycle decode read must see the pending write.
  assign byp1_hit  = RegWrite & (w_add == byp_rs1) & (byp_rs1 != '0);
  assign byp2_hit  = RegWrite & (w_add == byp_rs2) & (byp_rs2 != '0);
  assign byp1_data = byp1_hit ? RegWriteData : '0;
  assign byp2_data = byp2_hit ? RegWriteData : '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
// Checks outputs every cycle on the falling edge; optional bypass checks under WB_BYPASS_EN.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 4;
  localparam int STALL_MARGIN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        late_valid;
  logic [4:0]  late_rd;
  logic [31:0] late_data;
  logic        late_ready;
  logic        stall_req;
  logic        RegWrite;
  logic [4:0]  w_add;
  logic [31:0] RegWriteData;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_rs1, byp_rs2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp1_data, byp2_data;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .late_valid   (late_valid),
    .late_rd      (late_rd),
    .late_data    (late_data),
    .late_ready   (late_ready),
    .stall_req    (stall_req),
    .RegWrite     (RegWrite),
    .w_add        (w_add),
    .RegWriteData (RegWriteData)
`ifdef WB_BYPASS_EN
    ,
    .byp_rs1      (byp_rs1),
    .byp_rs2      (byp_rs2),
    .byp1_hit     (byp1_hit),
    .byp2_hit     (byp2_hit),
    .byp1_data    (byp1_data),
    .byp2_data    (byp2_data)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queued late results plus the write the port should show.
  logic [36:0] q[$];
  logic        exp_we   = 1'b0;
  logic [4:0]  exp_add  = '0;
  logic [31:0] exp_data = '0;
  logic [4:0]  next_rs1 = '0;
  logic [4:0]  next_rs2 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int free_cnt;
    free_cnt = DEPTH - q.size();
    chk("RegWrite", 32'(RegWrite), 32'(exp_we));
    chk("w_add", 32'(w_add), 32'(exp_add));
    chk("RegWriteData", RegWriteData, exp_data);
    chk("late_ready", 32'(late_ready), 32'(q.size() < DEPTH));
    chk("stall_req", 32'(stall_req), 32'(free_cnt <= STALL_MARGIN));
`ifdef WB_BYPASS_EN
    begin
      logic h1, h2;
      h1 = exp_we && (exp_add == next_rs1) && (next_rs1 != 0);
      h2 = exp_we && (exp_add == next_rs2) && (next_rs2 != 0);
      chk("byp1_hit", 32'(byp1_hit), 32'(h1));
      chk("byp2_hit", 32'(byp2_hit), 32'(h2));
      chk("byp1_data", byp1_data, h1 ? exp_data : 32'h0);
      chk("byp2_data", byp2_data, h2 ? exp_data : 32'h0);
    end
`endif
  endtask

  // One clock cycle: check current outputs, drive new inputs, advance the model.
  task automatic cyc(input logic r, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic hs;
    logic [36:0] e;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    byp_rs1 = next_rs1;
    byp_rs2 = next_rs2;
`endif
    #1;
    check_outputs();
    rst = r; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    late_valid = lv; late_rd = lrd; late_data = ld;
    if (!r) begin
      q.delete();
      exp_we = 1'b0; exp_add = '0; exp_data = '0;
    end else begin
      hs = lv && (q.size() < DEPTH);
      if (wv && wrd != 0) begin
        exp_we = 1'b1; exp_add = wrd; exp_data = wd;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        exp_we = 1'b1; exp_add = e[36:32]; exp_data = e[31:0];
      end else begin
        exp_we = 1'b0;
      end
      if (hs && lrd != 0) q.push_back({lrd, ld});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1;
    late_valid = 1'b0; late_rd = '0; late_data = '0;
`ifdef WB_BYPASS_EN
    byp_rs1 = '0; byp_rs2 = '0;
`endif
    @(posedge clk);

    // Reset held with pipeline valid, then a first pipeline write.
    cyc(0, 1, 5'd9, 32'h1, 0, 0, 0);
    cyc(0, 1, 5'd9, 32'h1, 0, 0, 0);
    cyc(1, 1, 5'd5, 32'h2A, 0, 0, 0);
    idle(2);

    // x0 writes from both streams.
    cyc(1, 1, 5'd0, 32'hBAD0, 0, 0, 0);
    cyc(1, 0, 5'd0, 0, 1, 5'd0, 32'hBAD1);
    idle(3);

    // Pipeline priority with two late entries behind it.
    cyc(1, 1, 5'd1, 32'h101, 1, 5'd3, 32'h11);
    cyc(1, 1, 5'd2, 32'h102, 1, 5'd4, 32'h22);
    cyc(1, 1, 5'd3, 32'h103, 0, 0, 0);
    idle(4);

    // Fill the queue under continuous pipeline writes, then drain.
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 5'(10 + i), 32'h200 + i, 1, 5'(20 + i), 32'h300 + i);
    idle(7);

    // Reset mid-operation with a handshake offered in the reset cycle.
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 5'(1 + i), 32'h400 + i, 1, 5'(6 + i), 32'h500 + i);
    cyc(0, 1, 5'd2, 32'h600, 1, 5'd9, 32'h601);
    idle(6);

    // Bypass hit on the cycle a write is presented.
    cyc(1, 1, 5'd7, 32'hDEAD, 0, 0, 0);
    next_rs1 = 5'd7; next_rs2 = 5'd0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    next_rs1 = 5'd0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, wv, lv;
      logic [4:0] wrd, lrd;
      r   = ($urandom_range(0, 99) >= 2);
      wv  = ($urandom_range(0, 99) < 55);
      lv  = ($urandom_range(0, 99) < 60);
      wrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      next_rs1 = ($urandom_range(0, 1) == 1) ? exp_add : 5'($urandom_range(0, 31));
      next_rs2 = 5'($urandom_range(0, 31));
      cyc(r, wv, wrd, $urandom, lv, lrd, $urandom);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
